// File: rtl/bemicro_cv_nios_cpu_oci_dct_packer.sv
// bemicro_cv_nios_cpu_oci_dct_packer: packs 2-bit trace codes into DCT words with a valid/ready output and drop accounting
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   trc_on            trace enable; gates incoming codes only
//   code_valid, code  incoming trace code
//   flush             seal the partial word now
//   dct_buffer        packed word, first code in entry 0, unused entries 0
//   dct_count         number of valid entries in dct_buffer
//   dct_valid         output word valid; consumed when dct_ready is high
//   dct_ready         downstream accept
//   overflow          sticky drop flag
//   overflow_clr      clears overflow and drop_count
//   drop_count        saturating count of dropped codes
module bemicro_cv_nios_cpu_oci_dct_packer #(
  parameter int ENTRY_W = 2,
  parameter int DEPTH = 15,
  parameter int COUNT_W = 4,
  parameter int DROP_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       trc_on,
  input  logic                       code_valid,
  input  logic [ENTRY_W-1:0]         code,
  input  logic                       flush,
  output logic [ENTRY_W*DEPTH-1:0]   dct_buffer,
  output logic [COUNT_W-1:0]         dct_count,
  output logic                       dct_valid,
  input  logic                       dct_ready,
  output logic                       overflow,
  input  logic                       overflow_clr,
  output logic [DROP_W-1:0]          drop_count
);
  localparam int W = ENTRY_W * DEPTH;
  typedef enum logic [1:0] {EMPTY, FILL, PEND} state_t;
  state_t state_q, state_d;
  logic [W-1:0] acc_q, acc_d, buf_q, buf_d, nxt_acc;
  logic [COUNT_W-1:0] acc_cnt_q, acc_cnt_d, cnt_q, cnt_d, nxt_cnt;
  logic valid_q, valid_d, ovf_q, ovf_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic slot_free, accept, drop, seal, xfer;
  assign slot_free = !valid_q || dct_ready;
  assign accept = code_valid && trc_on && state_q != PEND;
  assign drop = code_valid && trc_on && state_q == PEND;
  assign nxt_cnt = acc_cnt_q + COUNT_W'(accept);
  // entries above acc_cnt are always zero, so OR-ing the new code in is enough
  assign nxt_acc = accept ? acc_q | (W'(code) << (acc_cnt_q * ENTRY_W)) : acc_q;
  assign seal = state_q != PEND && (nxt_cnt == COUNT_W'(DEPTH) || (flush && nxt_cnt != '0));
  assign xfer = (seal && slot_free) || (state_q == PEND && dct_ready);
  always_comb begin
    state_d = xfer ? EMPTY : (seal || state_q == PEND) ? PEND : (nxt_cnt == '0 ? EMPTY : FILL);
    acc_d = xfer ? '0 : nxt_acc;
    acc_cnt_d = xfer ? '0 : nxt_cnt;
    buf_d = xfer ? nxt_acc : buf_q;
    cnt_d = xfer ? nxt_cnt : cnt_q;
    valid_d = xfer || (valid_q && !dct_ready);
    ovf_d = overflow_clr ? 1'b0 : (ovf_q || drop);
    drop_d = overflow_clr ? '0 : (drop && drop_q != '1) ? drop_q + 1'b1 : drop_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      acc_q <= '0;
      acc_cnt_q <= '0;
      buf_q <= '0;
      cnt_q <= '0;
      valid_q <= 1'b0;
      ovf_q <= 1'b0;
      drop_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      acc_cnt_q <= acc_cnt_d;
      buf_q <= buf_d;
      cnt_q <= cnt_d;
      valid_q <= valid_d;
      ovf_q <= ovf_d;
      drop_q <= drop_d;
    end
  end
  assign dct_buffer = buf_q;
  assign dct_count = cnt_q;
  assign dct_valid = valid_q;
  assign overflow = ovf_q;
  assign drop_count = drop_q;
endmodule
